ir_xmt: RTL



---
 rtl/ir_xmt_pkg.sv | 57 +++++
 rtl/ir_xmt_carrier_gen.sv | 49 ++++
 rtl/ir_xmt.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ir_xmt_pkg.sv
// ---------------------------------------------------------------------------
// ir_xmt_pkg
// Shared NEC protocol definitions for the IR transmitter (and the receive-side
// timing checks in ir_rcv): sequencer state encoding, segment lengths in NEC
// units, and small helpers that map a state to its envelope level and its
// length.
// ---------------------------------------------------------------------------
package ir_xmt_pkg;

    // Sequencer states. Mark states drive the envelope high, space states low.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_LEAD_MARK  = 4'd1,
        ST_LEAD_SPACE = 4'd2,
        ST_BIT_MARK   = 4'd3,
        ST_BIT_SPACE  = 4'd4,
        ST_STOP_MARK  = 4'd5,
        ST_GAP        = 4'd6,
        ST_RPT_MARK   = 4'd7,
        ST_RPT_SPACE  = 4'd8,
        ST_RPT_STOP   = 4'd9
    } xmt_state_t;

    // Segment lengths in NEC units (one unit = 562.5 us).
    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int RPT_SPACE_U  = 4;
    localparam int BIT_MARK_U   = 1;
    localparam int ZERO_SPACE_U = 1;
    localparam int ONE_SPACE_U  = 3;
    localparam int FRAME_U      = 192;

    // True for states in which the LED envelope is a mark.
    function automatic logic is_mark_state(input xmt_state_t s);
        return (s == ST_LEAD_MARK) || (s == ST_BIT_MARK) || (s == ST_STOP_MARK) ||
               (s == ST_RPT_MARK)  || (s == ST_RPT_STOP);
    endfunction

    // Length of the current segment in units. GAP is ended by the frame
    // counter rather than by a segment length, so it reports a dummy value.
    function automatic logic [4:0] seg_units(input xmt_state_t s, input logic bit_val);
        logic [4:0] len;
        case (s)
            ST_LEAD_MARK:  len = 5'(LEAD_MARK_U);
            ST_LEAD_SPACE: len = 5'(LEAD_SPACE_U);
            ST_BIT_MARK:   len = 5'(BIT_MARK_U);
            ST_BIT_SPACE:  len = bit_val ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U);
            ST_STOP_MARK:  len = 5'(BIT_MARK_U);
            ST_RPT_MARK:   len = 5'(LEAD_MARK_U);
            ST_RPT_SPACE:  len = 5'(RPT_SPACE_U);
            ST_RPT_STOP:   len = 5'(BIT_MARK_U);
            default:       len = 5'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ir_xmt_carrier_gen.sv
// ---------------------------------------------------------------------------
// ir_carrier_gen
// Free-running carrier phase counter for the NEC transmitter (~38 kHz at
// 50 MHz with default parameters).
//
// Ports:
//   clk50       in   system clock
//   reset       in   synchronous active-high reset
//   phase_rst   in   restart the carrier period on this edge (start of a mark)
//   car_on_next out  carrier level that applies after this edge; lets the
//                    parent register ir_tx in the same stage as ir_env
// ---------------------------------------------------------------------------
module ir_carrier_gen #(
    parameter int CARRIER_DIV  = 1316,
    parameter int CARRIER_HIGH = 439
) (
    input  logic clk50,
    input  logic reset,
    input  logic phase_rst,
    output logic car_on_next
);

    localparam logic [10:0] DIV_LAST = 11'(CARRIER_DIV - 1);
    localparam logic [10:0] HIGH_LIM = 11'(CARRIER_HIGH);

    logic [10:0] car_cnt;
    logic [10:0] car_next;

    // Next phase value: a phase reset wins so every mark begins at the start
    // of the high part of the carrier period.
    always_comb begin
        car_next = car_cnt + 11'd1;
        if (phase_rst || car_cnt == DIV_LAST) begin
            car_next = 11'd0;
        end
    end

    assign car_on_next = (car_next < HIGH_LIM);

    // Phase counter register.
    always_ff @(posedge clk50) begin
        if (reset) begin
            car_cnt <= 11'd0;
        end else begin
            car_cnt <= car_next;
        end
    end

endmodule

// File: rtl/ir_xmt.sv
// ---------------------------------------------------------------------------
// ir_xmt
// NEC infrared transmitter. Sends leader, 32 data bits (LSB first), a stop
// mark and a gap padding each frame to 192 units; while tx_repeat is high at
// the end of a frame it follows up with NEC repeat frames.
//
// Ports:
//   clk50      in   system clock (50 MHz)
//   reset      in   synchronous active-high reset, aborts any frame at once
//   ir_code    in   32-bit code, captured when a request is accepted
//   tx_req     in   start request, only honoured in IDLE
//   tx_repeat  in   sampled at frame end: high sends another repeat frame
//   busy       out  high from acceptance until return to IDLE
//   done       out  one-cycle pulse on the return to IDLE
//   ir_env     out  unmodulated envelope (1 = mark)
//   ir_tx      out  carrier-modulated envelope for the LED driver
// ---------------------------------------------------------------------------
module ir_xmt
    import ir_xmt_pkg::*;
#(
    parameter int UNIT_CYCLES  = 28125,
    parameter int CARRIER_DIV  = 1316,
    parameter int CARRIER_HIGH = 439
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [31:0] ir_code,
    input  logic        tx_req,
    input  logic        tx_repeat,
    output logic        busy,
    output logic        done,
    output logic        ir_env,
    output logic        ir_tx
);

    localparam logic [14:0] UNIT_LAST  = 15'(UNIT_CYCLES - 1);
    localparam logic [7:0]  FRAME_LAST = 8'(FRAME_U - 1);

    xmt_state_t  state;
    xmt_state_t  next_state;
    logic [14:0] unit_cnt;
    logic [4:0]  seg_cnt;
    logic [7:0]  frm_cnt;
    logic [4:0]  bit_idx;
    logic [31:0] shift_reg;

    logic unit_tick;
    logic seg_last;
    logic frame_last;
    logic accept;

    logic env_next;
    logic busy_next;
    logic done_next;
    logic phase_rst;
    logic car_on_next;

    assign accept     = (state == ST_IDLE) && tx_req;
    assign unit_tick  = (state != ST_IDLE) && (unit_cnt == UNIT_LAST);
    assign seg_last   = unit_tick && (seg_cnt == seg_units(state, shift_reg[0]) - 5'd1);
    assign frame_last = unit_tick && (frm_cnt == FRAME_LAST);

    // State register. Reset returns straight to IDLE without passing through
    // the done logic, so an aborted frame never pulses done.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Segment states advance on the last unit tick of their
    // segment; GAP waits for the frame counter so every frame is 192 units.
    // At GAP exit a pending repeat takes priority, and tx_req is only looked
    // at in IDLE, so a request during a frame is simply dropped.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (tx_req)   next_state = ST_LEAD_MARK;
            ST_LEAD_MARK:  if (seg_last) next_state = ST_LEAD_SPACE;
            ST_LEAD_SPACE: if (seg_last) next_state = ST_BIT_MARK;
            ST_BIT_MARK:   if (seg_last) next_state = ST_BIT_SPACE;
            ST_BIT_SPACE:  if (seg_last) next_state = (bit_idx == 5'd31) ? ST_STOP_MARK : ST_BIT_MARK;
            ST_STOP_MARK:  if (seg_last) next_state = ST_GAP;
            ST_GAP:        if (frame_last) next_state = tx_repeat ? ST_RPT_MARK : ST_IDLE;
            ST_RPT_MARK:   if (seg_last) next_state = ST_RPT_SPACE;
            ST_RPT_SPACE:  if (seg_last) next_state = ST_RPT_STOP;
            ST_RPT_STOP:   if (seg_last) next_state = ST_GAP;
            default:       next_state = ST_IDLE;
        endcase
    end

    // Output decode. Outputs are derived from the state being entered so
    // that, once registered, they line up with the state register itself.
    // The carrier phase is restarted whenever the envelope goes space->mark.
    always_comb begin
        env_next  = is_mark_state(next_state);
        busy_next = (next_state != ST_IDLE);
        done_next = (state == ST_GAP) && (next_state == ST_IDLE);
        phase_rst = env_next && !ir_env;
    end

    // Output registers; ir_tx is registered alongside ir_env so the carrier
    // can never leak outside a mark.
    always_ff @(posedge clk50) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            ir_env <= 1'b0;
            ir_tx  <= 1'b0;
        end else begin
            busy   <= busy_next;
            done   <= done_next;
            ir_env <= env_next;
            ir_tx  <= env_next && car_on_next;
        end
    end

    // Unit timer, segment/frame counters and the code shift register.
    // Acceptance clears the unit timer so unit boundaries line up with the
    // leader start. The shift register moves on at the end of each bit
    // space, leaving the next bit to send in shift_reg[0].
    always_ff @(posedge clk50) begin
        if (reset) begin
            unit_cnt  <= 15'd0;
            seg_cnt   <= 5'd0;
            frm_cnt   <= 8'd0;
            bit_idx   <= 5'd0;
            shift_reg <= 32'd0;
        end else if (accept) begin
            unit_cnt  <= 15'd0;
            seg_cnt   <= 5'd0;
            frm_cnt   <= 8'd0;
            bit_idx   <= 5'd0;
            shift_reg <= ir_code;
        end else if (state != ST_IDLE) begin
            unit_cnt <= unit_tick ? 15'd0 : unit_cnt + 15'd1;

            if (next_state != state) begin
                seg_cnt <= 5'd0;
            end else if (unit_tick) begin
                seg_cnt <= seg_cnt + 5'd1;
            end

            if (frame_last) begin
                frm_cnt <= 8'd0;
            end else if (unit_tick) begin
                frm_cnt <= frm_cnt + 8'd1;
            end

            if (state == ST_BIT_SPACE && seg_last) begin
                shift_reg <= shift_reg >> 1;
                bit_idx   <= bit_idx + 5'd1;
            end
        end else begin
            unit_cnt <= 15'd0;
            seg_cnt  <= 5'd0;
            frm_cnt  <= 8'd0;
        end
    end

    ir_carrier_gen #(
        .CARRIER_DIV (CARRIER_DIV),
        .CARRIER_HIGH(CARRIER_HIGH)
    ) u_carrier (
        .clk50      (clk50),
        .reset      (reset),
        .phase_rst  (phase_rst),
        .car_on_next(car_on_next)
    );

endmodule
